// File: rtl/tty10_pkg.sv
// tty10_pkg: shared constants for the KA10 console teletype interface.
//   - Default device code and I/O-bus bit positions (PDP-10 numbering, bit 35 = LSB).
//   - Transmit FSM state encoding.
//   - Helper that turns a PI assignment into a one-hot request vector.
package tty10_pkg;

    localparam logic [6:0] DevCodeDefault = 7'o24;

    // CONI status word layout
    localparam int unsigned ConiTtiBusy = 28;
    localparam int unsigned ConiTtiFlag = 29;
    localparam int unsigned ConiTtoBusy = 30;
    localparam int unsigned ConiTtoFlag = 31;
    localparam int unsigned PiaMsb      = 33;  // pia occupies [33:35] in CONI and CONO

    // CONO set bits
    localparam int unsigned ConoTtoFlag = 31;
    localparam int unsigned ConoTtiFlag = 32;

    // Character field for DATAO/DATAI, [28:35]
    localparam int unsigned DataMsb = 28;

    // Transmit FSM states
    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StSend = 2'd1;
    localparam logic [1:0] StWait = 2'd2;

    typedef logic [0:35] word_t;
    typedef logic [1:7]  pi_t;

    // Channel 0 means "no interrupt", so it yields an all-zero vector.
    function automatic pi_t pi_onehot(input logic [2:0] pia);
        pi_t r;
        for (int i = 1; i <= 7; i++) begin
            r[i] = (pia == 3'(i));
        end
        return r;
    endfunction

endpackage

// File: rtl/tty10_tx.sv
// tty10_tx: output-character sequencer for tty10.
//   clk_i      : system clock
//   clr_i      : synchronous clear (system reset or I/O-bus reset); also masks tx_valid_o
//   start_i    : DATAO set accepted this cycle
//   data_i     : character to send (the output buffer's next value)
//   tx_ready_i : transmitter accepts the presented character
//   tx_valid_o : character presented (SEND)
//   tx_data_o  : presented character, held stable while tx_valid_o is high
//   done_o     : pulse on the last WAIT cycle (character time elapsed)
//   chain_o    : with done_o, a further character goes straight back to SEND
module tty10_tx
    import tty10_pkg::*;
#(
    parameter int unsigned char_cycles = 1000
) (
    input  logic       clk_i,
    input  logic       clr_i,
    input  logic       start_i,
    input  logic [7:0] data_i,
    input  logic       tx_ready_i,
    output logic       tx_valid_o,
    output logic [7:0] tx_data_o,
    output logic       done_o,
    output logic       chain_o
);

    localparam int unsigned     CntW    = (char_cycles > 1) ? $clog2(char_cycles) : 1;
    localparam logic [CntW-1:0] CntLoad = CntW'(char_cycles - 1);

    logic [1:0]      state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            pend_q, pend_d;
    logic [7:0]      data_q, data_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        data_d  = data_q;
        done_o  = 1'b0;
        chain_o = 1'b0;
        case (state_q)
            StIdle: begin
                if (start_i) begin
                    state_d = StSend;
                    data_d  = data_i;
                end
            end
            StSend: begin
                // A reload while presenting is queued so tx_data_o stays stable.
                if (start_i) pend_d = 1'b1;
                if (tx_ready_i) begin
                    state_d = StWait;
                    cnt_d   = CntLoad;
                end
            end
            StWait: begin
                if (start_i) pend_d = 1'b1;
                if (cnt_q == '0) begin
                    done_o = 1'b1;
                    if (pend_q || start_i) begin
                        chain_o = 1'b1;
                        state_d = StSend;
                        data_d  = data_i;
                        pend_d  = 1'b0;
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (clr_i) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            pend_q  <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            data_q  <= data_d;
        end
    end

    // An I/O-bus reset abandons the character immediately, not one cycle later.
    assign tx_valid_o = (state_q == StSend) && !clr_i;
    assign tx_data_o  = data_q;

endmodule

// File: rtl/tty10.sv
// tty10: KA10 console teletype on the I/O bus.
//   clk, reset              : clock, synchronous active-high reset
//   iobus_iob_reset         : bus reset, same effect as reset
//   iobus_ios               : selected device number, matched against dev_code
//   iobus_cono_*/datao_*    : CONO/DATAO clear and set pulses
//   iobus_iob_coni/datai    : CONI/DATAI read levels
//   iobus_iob_out/_in       : bus data from / to the CPU (in is zero unless read)
//   iobus_pi                : registered one-hot PI request
//   tx_data/tx_valid/ready  : output character stream
//   rx_data/rx_valid        : received character strobe
module tty10
    import tty10_pkg::*;
#(
    parameter logic [6:0]  dev_code    = DevCodeDefault,
    parameter int unsigned char_cycles = 1000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        iobus_iob_reset,
    input  logic [3:9]  iobus_ios,
    input  logic        iobus_cono_clear,
    input  logic        iobus_cono_set,
    input  logic        iobus_datao_clear,
    input  logic        iobus_datao_set,
    input  logic        iobus_iob_coni,
    input  logic        iobus_iob_datai,
    input  logic [0:35] iobus_iob_out,
    output logic [0:35] iobus_iob_in,
    output logic [1:7]  iobus_pi,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid
);

    logic       clr, sel;
    logic       cono_clr, cono_set, datao_clr, datao_set, datai_sel, datai_end;
    logic       tx_done, tx_chain;

    logic [2:0] pia_q, pia_d;
    logic [7:0] tti_buf_q, tti_buf_d, tto_buf_q, tto_buf_d;
    logic       tti_flag_q, tti_flag_d, tti_busy_q, tti_busy_d;
    logic       tto_flag_q, tto_flag_d, tto_busy_q, tto_busy_d;
    logic       datai_q, datai_d;
    pi_t        pi_q, pi_d;

    logic       unused_out;
    assign unused_out = ^iobus_iob_out[0:27];

    assign clr = reset || iobus_iob_reset;
    assign sel = (iobus_ios == dev_code);

    // A clear pulse overrides a coincident set pulse of the same instruction.
    assign cono_clr  = sel && iobus_cono_clear;
    assign cono_set  = sel && iobus_cono_set && !iobus_cono_clear;
    assign datao_clr = sel && iobus_datao_clear;
    assign datao_set = sel && iobus_datao_set && !iobus_datao_clear;
    assign datai_sel = sel && iobus_iob_datai;
    assign datai_end = datai_q && !iobus_iob_datai;

    always_comb begin
        pia_d = pia_q;
        if (cono_set) pia_d = pia_q | iobus_iob_out[PiaMsb +: 3];
        if (cono_clr) pia_d = '0;

        tti_buf_d  = rx_valid ? rx_data : tti_buf_q;
        tti_busy_d = rx_valid;

        // Later assignments win: a new character survives the DATAI-end clear.
        tti_flag_d = tti_flag_q;
        if (datai_end) tti_flag_d = 1'b0;
        if (rx_valid) tti_flag_d = 1'b1;
        if (cono_set && iobus_iob_out[ConoTtiFlag]) tti_flag_d = 1'b1;
        if (cono_clr) tti_flag_d = 1'b0;

        tto_buf_d = tto_buf_q;
        if (datao_set) tto_buf_d = tto_buf_q | iobus_iob_out[DataMsb +: 8];
        if (datao_clr) tto_buf_d = '0;

        tto_flag_d = tto_flag_q;
        if (tx_done) tto_flag_d = 1'b1;
        if (cono_set && iobus_iob_out[ConoTtoFlag]) tto_flag_d = 1'b1;
        if (cono_clr || datao_clr) tto_flag_d = 1'b0;

        // Busy stays up across back-to-back characters.
        tto_busy_d = tto_busy_q;
        if (tx_done && !tx_chain) tto_busy_d = 1'b0;
        if (datao_set) tto_busy_d = 1'b1;

        datai_d = datai_sel;
        pi_d    = (tti_flag_q || tto_flag_q) ? pi_onehot(pia_q) : '0;
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            pia_q      <= '0;
            tti_buf_q  <= '0;
            tti_flag_q <= 1'b0;
            tti_busy_q <= 1'b0;
            tto_buf_q  <= '0;
            tto_flag_q <= 1'b0;
            tto_busy_q <= 1'b0;
            datai_q    <= 1'b0;
            pi_q       <= '0;
        end else begin
            pia_q      <= pia_d;
            tti_buf_q  <= tti_buf_d;
            tti_flag_q <= tti_flag_d;
            tti_busy_q <= tti_busy_d;
            tto_buf_q  <= tto_buf_d;
            tto_flag_q <= tto_flag_d;
            tto_busy_q <= tto_busy_d;
            datai_q    <= datai_d;
            pi_q       <= pi_d;
        end
    end

    always_comb begin
        iobus_iob_in = '0;
        if (sel && iobus_iob_coni) begin
            iobus_iob_in[ConiTtiBusy]  = tti_busy_q;
            iobus_iob_in[ConiTtiFlag]  = tti_flag_q;
            iobus_iob_in[ConiTtoBusy]  = tto_busy_q;
            iobus_iob_in[ConiTtoFlag]  = tto_flag_q;
            iobus_iob_in[PiaMsb +: 3] = pia_q;
        end
        if (datai_sel) begin
            iobus_iob_in[DataMsb +: 8] = iobus_iob_in[DataMsb +: 8] | tti_buf_q;
        end
    end

    assign iobus_pi = pi_q;

    tty10_tx #(
        .char_cycles(char_cycles)
    ) u_tx (
        .clk_i     (clk),
        .clr_i     (clr),
        .start_i   (datao_set),
        .data_i    (tto_buf_d),
        .tx_ready_i(tx_ready),
        .tx_valid_o(tx_valid),
        .tx_data_o (tx_data),
        .done_o    (tx_done),
        .chain_o   (tx_chain)
    );

endmodule
